// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the fetch-controller state encoding.
package mips_pkg;

  localparam logic [5:0]  OP_RTYPE      = 6'h00;
  localparam logic [5:0]  OP_J          = 6'h02;
  localparam logic [5:0]  OP_BEQ        = 6'h04;
  localparam logic [5:0]  OP_BNE        = 6'h05;
  localparam logic [5:0]  FUNCT_SYSCALL = 6'h0C;
  localparam logic [31:0] NOP_INST      = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_next_pc_calc.sv
// Combinational next-PC computation for sequential, jump and branch flow,
// plus SYSCALL detection.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic        br_taken_i,
  output logic [31:0] next_pc_o,
  output logic        is_syscall_o
);

  logic [31:0] pc4_s;
  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;

  // Decode the fetched word and select the flow-change target
  always_comb begin
    pc4_s        = pc_i + 32'd4;
    opcode_s     = inst_i[31:26];
    funct_s      = inst_i[5:0];
    is_syscall_o = (opcode_s == OP_RTYPE) && (funct_s == FUNCT_SYSCALL);
    if (is_syscall_o) begin
      next_pc_o = pc_i;
    end else if (opcode_s == OP_J) begin
      next_pc_o = {pc4_s[31:28], inst_i[25:0], 2'b00};
    end else if (((opcode_s == OP_BEQ) || (opcode_s == OP_BNE)) && br_taken_i) begin
      next_pc_o = pc4_s + br_offset(inst_i[15:0]);
    end else begin
      next_pc_o = pc4_s;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer and instruction-memory port owner (fetch vs. byte loader).
// Optional cycle counters are enabled by defining IMEM_FETCH_PERF_EN.
module imem_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int          MEM_BYTES = 256,
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              br_taken,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_inst,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [7:0]        imem_wdata,
  input  logic              ld_req,
  output logic              ld_gnt,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  input  logic              ld_done,
  output logic [31:0]       pc,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              halted,
  output logic              fault
`ifdef IMEM_FETCH_PERF_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [31:0] PC_MAX = 32'(MEM_BYTES - 4);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         halted_q, halted_d;
  logic         fault_q, fault_d;
  logic [31:0]  calc_pc_s;
  logic         is_syscall_s;
  logic         start_acc_s;

  next_pc_calc u_next_pc (
    .pc_i        (pc_q),
    .inst_i      (imem_inst),
    .br_taken_i  (br_taken),
    .next_pc_o   (calc_pc_s),
    .is_syscall_o(is_syscall_s)
  );

  // State, PC and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  // Next-state logic; a pending loader request always beats start
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    halted_d    = halted_q;
    fault_d     = fault_q;
    start_acc_s = 1'b0;
    case (state_q)
      IDLE, HALT: begin
        if (ld_req) begin
          state_d  = LOAD;
          halted_d = 1'b0;
          fault_d  = 1'b0;
        end else if (start) begin
          state_d     = RUN;
          pc_d        = RESET_PC;
          halted_d    = 1'b0;
          fault_d     = 1'b0;
          start_acc_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      LOAD: begin
        if (ld_done) begin
          state_d = IDLE;
        end else begin
          state_d = LOAD;
        end
      end
      RUN: begin
        if (stall) begin
          pc_d = pc_q;
        end else if (is_syscall_s) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else begin
          // The offending PC is kept so the datapath can report it
          pc_d = calc_pc_s;
          if (calc_pc_s > PC_MAX) begin
            state_d  = HALT;
            halted_d = 1'b1;
            fault_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign inst_valid = (state_q == RUN);
  assign inst       = inst_valid ? imem_inst : NOP_INST;
  assign ld_gnt     = (state_q == LOAD);
  assign imem_we    = ld_gnt && ld_valid;
  assign imem_waddr = ld_gnt ? ld_addr : '0;
  assign imem_wdata = ld_gnt ? ld_data : 8'h00;

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] retired_q;
  logic [31:0] stall_q;

  // Saturating retire/stall cycle counters, cleared whenever a run starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= 32'd0;
      stall_q   <= 32'd0;
    end else if (start_acc_s) begin
      retired_q <= 32'd0;
      stall_q   <= 32'd0;
    end else if (state_q == RUN) begin
      if (stall) begin
        if (stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
      end else begin
        if (retired_q != 32'hFFFF_FFFF) retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed table, multi-cycle
// sequences and randomized programs checked against a behavioural model.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stall, br_taken;
  logic [31:0] imem_addr, imem_inst;
  logic        imem_we;
  logic [7:0]  imem_waddr, imem_wdata;
  logic        ld_req, ld_gnt, ld_valid, ld_done;
  logic [7:0]  ld_addr, ld_data;
  logic [31:0] pc, inst;
  logic        inst_valid, halted, fault;

  imem_fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .br_taken(br_taken),
    .imem_addr(imem_addr), .imem_inst(imem_inst), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .ld_req(ld_req), .ld_gnt(ld_gnt), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_done(ld_done),
    .pc(pc), .inst(inst), .inst_valid(inst_valid), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // Byte-wide instruction memory with big-endian combinational word read
  logic [7:0] mem [0:255];
  logic [7:0] ra;
  int         we_cnt = 0;
  assign ra        = imem_addr[7:0];
  assign imem_inst = {mem[ra], mem[ra + 8'd1], mem[ra + 8'd2], mem[ra + 8'd3]};
  always @(posedge clk) begin
    if (imem_we === 1'b1) begin
      mem[imem_waddr] <= imem_wdata;
      we_cnt++;
    end
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] prog_w [0:63];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Load prog_w[first .. first+n-1] through the loader; last byte rides with ld_done
  task automatic load_words(input int first, input int n);
    int          base;
    logic [31:0] w;
    logic [7:0]  ea;
    base = we_cnt;
    @(negedge clk); ld_req = 1'b1;
    @(negedge clk); ld_req = 1'b0;
    for (int b = 0; b < 4 * n; b++) begin
      w        = prog_w[first + b / 4];
      ea       = 8'(4 * first + b);
      ld_valid = 1'b1;
      ld_addr  = ea;
      ld_data  = w[31 - 8 * (b % 4) -: 8];
      ld_done  = (b == 4 * n - 1);
      #1;
      chk("ld_gnt_load", {31'd0, ld_gnt}, 32'd1);
      chk("imem_we_load", {31'd0, imem_we}, 32'd1);
      chk("imem_waddr", {24'd0, imem_waddr}, {24'd0, ea});
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_done  = 1'b0;
    #1;
    chk("ld_gnt_released", {31'd0, ld_gnt}, 32'd0);
    chk("we_pulses", 32'(we_cnt - base), 32'(4 * n));
    for (int i = first; i < first + n; i++) begin
      chk("mem_word", {mem[4*i], mem[4*i+1], mem[4*i+2], mem[4*i+3]}, prog_w[i]);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        halted;
  } vec_t;
  vec_t vt [0:14];

  logic [31:0] exp_pcs [0:5];
  logic [31:0] m_pc, nxt, w;
  logic        m_run, m_fault;
  logic [5:0]  op;
  logic [15:0] o16;
  int          off, k;

  initial begin
    vt[0]  = '{1'b0, 1'b0, 32'd0,  32'h2003_0008, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 32'd4,  32'h0000_0000, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 32'd8,  32'h0000_0000, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 32'd12, 32'h1060_0005, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 32'd16, 32'h2063_FFFF, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 32'd20, 32'h0000_0000, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 32'd24, 32'h0000_0000, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 32'd28, 32'h0800_0003, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 32'd12, 32'h1060_0005, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 32'd36, 32'h0000_0000, 1'b1, 1'b0};
    vt[10] = '{1'b1, 1'b1, 32'd40, 32'h0000_000C, 1'b1, 1'b0};
    vt[11] = '{1'b1, 1'b0, 32'd40, 32'h0000_000C, 1'b1, 1'b0};
    vt[12] = '{1'b1, 1'b1, 32'd40, 32'h0000_000C, 1'b1, 1'b0};
    vt[13] = '{1'b0, 1'b0, 32'd40, 32'h0000_000C, 1'b1, 1'b0};
    vt[14] = '{1'b0, 1'b0, 32'd40, 32'h0000_0000, 1'b0, 1'b1};

    for (int i = 0; i < 64; i++) prog_w[i] = 32'h0000_0000;
    prog_w[0]  = 32'h2003_0008;
    prog_w[3]  = 32'h1060_0005;
    prog_w[4]  = 32'h2063_FFFF;
    prog_w[7]  = 32'h0800_0003;
    prog_w[10] = 32'h0000_000C;

    rst = 1'b1; start = 1'b0; stall = 1'b0; br_taken = 1'b0;
    ld_req = 1'b0; ld_valid = 1'b1; ld_done = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_ld_gnt", {31'd0, ld_gnt}, 32'd0);
    chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    rst = 1'b0; ld_valid = 1'b0;

    // Countdown program fill, then the directed flow table
    load_words(0, 11);
    pulse_start();
    for (int i = 0; i < 15; i++) begin
      stall = vt[i].stall; br_taken = vt[i].br;
      #1;
      chk("tbl_pc", pc, vt[i].pc);
      chk("tbl_inst", inst, vt[i].inst);
      chk("tbl_valid", {31'd0, inst_valid}, {31'd0, vt[i].valid});
      chk("tbl_halted", {31'd0, halted}, {31'd0, vt[i].halted});
      chk("tbl_imem_addr", imem_addr, vt[i].pc);
      @(negedge clk);
    end
    stall = 1'b0;
    chk("syscall_no_fault", {31'd0, fault}, 32'd0);

    // Patch a branch at 36 whose target is 256 and run into the fault
    prog_w[9] = 32'h1000_0036;
    load_words(9, 1);
    chk("load_clears_halted", {31'd0, halted}, 32'd0);
    br_taken = 1'b1;
    exp_pcs[0] = 32'd0; exp_pcs[1] = 32'd4; exp_pcs[2] = 32'd8;
    exp_pcs[3] = 32'd12; exp_pcs[4] = 32'd36;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      #1 chk("fault_seq_pc", pc, exp_pcs[i]);
      @(negedge clk);
    end
    #1;
    chk("fault_pc", pc, 32'd256);
    chk("fault_flag", {31'd0, fault}, 32'd1);
    chk("fault_halted", {31'd0, halted}, 32'd1);
    chk("fault_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("fault_inst", inst, 32'd0);
    pulse_start();
    #1;
    chk("restart_pc", pc, 32'd0);
    chk("restart_fault", {31'd0, fault}, 32'd0);
    chk("restart_halted", {31'd0, halted}, 32'd0);
    chk("restart_valid", {31'd0, inst_valid}, 32'd1);
    repeat (5) @(negedge clk);
    #1 chk("refault", {31'd0, fault}, 32'd1);

    // Restore, then request the loader while running
    prog_w[9] = 32'h0000_0000;
    load_words(9, 1);
    chk("load_clears_fault", {31'd0, fault}, 32'd0);
    pulse_start();
    ld_req = 1'b1;
    exp_pcs[5] = 32'd40;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("arb_pc", pc, exp_pcs[i]);
      chk("arb_gnt_run", {31'd0, ld_gnt}, 32'd0);
      @(negedge clk);
    end
    #1;
    chk("arb_halted", {31'd0, halted}, 32'd1);
    chk("arb_gnt_halt", {31'd0, ld_gnt}, 32'd0);
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 8'hF0; ld_data = 8'hA5;
    #1;
    chk("arb_gnt_load", {31'd0, ld_gnt}, 32'd1);
    chk("arb_we_load", {31'd0, imem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_load_we", {31'd0, imem_we}, 32'd0);
    chk("rst_load_gnt", {31'd0, ld_gnt}, 32'd0);
    chk("rst_load_pc", pc, 32'd0);
    @(negedge clk);
    rst = 1'b0; ld_req = 1'b0; ld_valid = 1'b0;
    #1;
    chk("idle_gnt", {31'd0, ld_gnt}, 32'd0);
    chk("idle_valid", {31'd0, inst_valid}, 32'd0);
    chk("idle_halted", {31'd0, halted}, 32'd0);

    // Randomized programs against the reference model
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 64; i++) begin
        k = $urandom_range(0, 19);
        if (k == 0) prog_w[i] = 32'h0000_000C;
        else if (k <= 3) prog_w[i] = {6'h02, 26'($urandom_range(0, 63))};
        else if (k <= 7) begin
          off = $urandom_range(0, 24) - 12;
          o16 = 16'(off);
          prog_w[i] = {(k[0] ? 6'h04 : 6'h05), 10'($urandom), o16};
        end else if (k == 8) prog_w[i] = 32'h0000_0000;
        else prog_w[i] = {6'h08, 26'($urandom)};
      end
      load_words(0, 64);
      pulse_start();
      m_pc = 32'd0; m_run = 1'b1; m_fault = 1'b0;
      for (int c = 0; c < 300 && m_run; c++) begin
        stall = ($urandom_range(0, 3) == 0);
        br_taken = $urandom_range(0, 1) == 1;
        #1;
        chk("rnd_pc", pc, m_pc);
        chk("rnd_inst", inst, prog_w[m_pc[7:2]]);
        chk("rnd_valid", {31'd0, inst_valid}, 32'd1);
        chk("rnd_halted", {31'd0, halted}, 32'd0);
        chk("rnd_gnt", {31'd0, ld_gnt}, 32'd0);
        @(negedge clk);
        if (!stall) begin
          w  = prog_w[m_pc[7:2]];
          op = w[31:26];
          if (op == 6'h00 && w[5:0] == 6'h0C) begin
            m_run = 1'b0;
          end else begin
            if (op == 6'h02) nxt = ((m_pc + 32'd4) & 32'hF000_0000) + (32'(w[25:0]) << 2);
            else if ((op == 6'h04 || op == 6'h05) && br_taken) begin
              off = $signed(w[15:0]);
              nxt = m_pc + 32'd4 + 32'(off * 4);
            end else nxt = m_pc + 32'd4;
            m_pc = nxt;
            if (nxt > 32'd252) begin
              m_run = 1'b0;
              m_fault = 1'b1;
            end
          end
        end
      end
      stall = 1'b0;
      #1;
      if (m_run) begin
        chk("rnd_still_running", {31'd0, inst_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        chk("rnd_end_pc", pc, m_pc);
        chk("rnd_end_halted", {31'd0, halted}, 32'd1);
        chk("rnd_end_fault", {31'd0, fault}, {31'd0, m_fault});
        chk("rnd_end_valid", {31'd0, inst_valid}, 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Fetch sequencer and port owner for the byte-addressed instruction memory (MEM_BYTES bytes, big-endian 32-bit reads at a byte address).
- Holds the PC and drives the memory read address.
- Computes the next PC for sequential, jump and branch flow.
- Detects SYSCALL to halt the core.
- Arbitrates the memory between the fetch path and a byte-wide program loader used before execution.

Parameters:
MEM_BYTES, 256, instruction memory size in bytes.
ADDR_W, 8, loader byte-address width; equals log2(MEM_BYTES).
RESET_PC, 32'h0000_0000, PC value loaded at reset and on every start.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse: begin execution at RESET_PC.
stall  in  1  datapath hold; the PC does not advance.
br_taken  in  1  datapath branch-condition result for the current instruction.
imem_addr  out  32  read byte address to the memory; equals pc.
imem_inst  in  32  combinational read data from the memory.
imem_we  out  1  memory byte write enable.
imem_waddr  out  ADDR_W  memory write byte address.
imem_wdata  out  8  memory write byte.
ld_req  in  1  loader requests the memory.
ld_gnt  out  1  loader owns the memory.
ld_valid  in  1  loader byte strobe.
ld_addr  in  ADDR_W  loader byte address.
ld_data  in  8  loader byte.
ld_done  in  1  loader releases the memory.
pc  out  32  current PC.
inst  out  32  instruction to the datapath; 32'h0 (NOP) unless inst_valid is high.
inst_valid  out  1  inst is a live instruction.
halted  out  1  core stopped by SYSCALL or a fault.
fault  out  1  sticky: PC out of range.

Behaviour:
- Reset (async): state=IDLE, pc=RESET_PC, halted=0, fault=0, ld_gnt=0, imem_we=0, inst_valid=0. Reset during LOAD aborts the load; imem_we drops immediately.
- FSM states: IDLE, LOAD, RUN, HALT.
- IDLE:
  - ld_req -> LOAD.
  - else start -> RUN with pc<=RESET_PC.
  - ld_req has priority over start.
- LOAD:
  - ld_gnt=1; imem_we=ld_valid; imem_waddr=ld_addr; imem_wdata=ld_data. The write path is combinational pass-through.
  - ld_done -> IDLE. A byte with ld_valid in the same cycle as ld_done is still written.
  - start is ignored in LOAD.
- RUN:
  - imem_addr=pc; inst=imem_inst; inst_valid=1.
  - One instruction per cycle, zero-cycle fetch latency.
- Next PC on each clock in RUN; first matching rule wins:
  1. stall=1: hold pc. SYSCALL and branch are not acted on.
  2. inst is SYSCALL (opcode 0, funct 6'h0C): hold pc; go to HALT; halted<=1.
  3. opcode 6'h02 (J): pc<={pc4[31:28], inst[25:0], 2'b00}, where pc4=pc+4.
  4. opcode 6'h04 (BEQ) or 6'h05 (BNE) with br_taken=1: pc<=pc4 + {{14{inst[15]}}, inst[15:0], 2'b00}.
  5. Otherwise: pc<=pc4.
- br_taken is ignored for non-branch opcodes.
- All PC arithmetic is 32-bit, wrapping modulo 2^32.
- Range check:
  - Whenever the next pc > MEM_BYTES-4, go to HALT with fault<=1 and halted<=1.
  - pc still takes the offending value so the datapath can report it.
- HALT:
  - inst=0; inst_valid=0; pc frozen.
  - ld_req -> LOAD, clearing halted and fault.
  - start -> RUN from RESET_PC, clearing halted and fault.
- ld_gnt is 0 outside LOAD. ld_req in RUN is held off until HALT.
- imem_we is 0 outside LOAD.

Optional Feature:
- Macro: IMEM_FETCH_PERF_EN.
- When defined, two extra output ports:
  - retired_cnt (out, 32): counts RUN cycles with stall=0, including the SYSCALL cycle.
  - stall_cnt (out, 32): counts RUN cycles with stall=1.
  - Both counters clear on reset and on start, and saturate at 32'hFFFF_FFFF.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE=6'h00, OP_J=6'h02, OP_BEQ=6'h04, OP_BNE=6'h05;
  - FUNCT_SYSCALL=6'h0C;
  - NOP_INST=32'h0;
  - the FSM state enum (IDLE, LOAD, RUN, HALT).
- One sub-module, next_pc_calc: a combinational block taking pc, inst and br_taken and producing next_pc and is_syscall.
- The FSM and the loader arbitration stay in the top module.

Test Plan:
1. Loader fill: ld_req, 44 bytes of the countdown program starting at 8'h20,8'h03,8'h00,8'h08, then ld_done -> ld_gnt=1 throughout, 44 imem_we pulses with matching addresses, return to IDLE.
2. Sequential flow: start -> pc runs 0,4,8,12 on consecutive cycles; inst at pc=0 is 32'h2003_0008.
3. Jump: pc=28 fetches 32'h0800_0003 -> next pc=12. Branch: pc=12, inst 32'h1060_0005, br_taken=1 -> next pc=36; same with br_taken=0 -> next pc=16.
4. Stall on SYSCALL: stall=1 for 3 cycles at pc=40 (32'h0000_000C) -> pc holds at 40, halted=0. On stall release -> HALT next cycle, halted=1, inst_valid=0, pc=40.
5. Fault: a branch whose target is 256 -> fault=1, halted=1, pc=256. A later start clears both and pc=0.
6. Arbitration and reset: ld_req asserted in RUN -> ld_gnt stays 0 until after SYSCALL. rst asserted mid-LOAD -> imem_we=0 and ld_gnt=0 immediately, state IDLE.
